// File: rtl/majority_vote_arbiter_if.sv
// majority_vote_arbiter_if
//   Bundles the two requester word ports and the result port of the shared
//   majority-vote engine.
//   Requester side : reqN_valid, reqN_data (to engine), reqN_ready (from engine)
//   Result side    : out_valid, out_id, out_count, out_result, busy (from engine),
//                    out_ready (to engine)
//   modport master : word sources / result consumer
//   modport slave  : the engine itself
interface majority_vote_arbiter_if #(
  parameter int WIDTH = 16
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             out_valid;
  logic             out_ready;
  logic             out_id;
  logic [CNT_W-1:0] out_count;
  logic             out_result;
  logic             busy;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, out_ready,
    input  req0_ready, req1_ready, out_valid, out_id, out_count, out_result, busy
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
    output req0_ready, req1_ready, out_valid, out_id, out_count, out_result, busy
  );
endinterface

// File: rtl/majority_vote_arbiter.sv
// majority_vote_arbiter
//   Time-shared bit-serial ones counter serving two requesters. A round-robin
//   arbiter accepts one word in IDLE, the word is scanned LSB first at one bit
//   per cycle in SCAN, and the count plus majority decision (count >= THRESHOLD)
//   is held on the result port in HOLD until the consumer takes it.
//   Ports:
//     clk  : clock, rising edge
//     rst  : synchronous active-high reset
//     bus  : majority_vote_arbiter_if.slave (requester and result handshakes)
//   Parameters:
//     WIDTH     : word width
//     THRESHOLD : minimum ones count for a 1 decision (1..WIDTH)
module majority_vote_arbiter #(
  parameter int WIDTH     = 16,
  parameter int THRESHOLD = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  majority_vote_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] THR      = CNT_W'(THRESHOLD);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] shift_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_sum;
  logic [IDX_W-1:0] index_q;
  logic [CNT_W-1:0] out_count_q;
  logic             out_result_q;
  logic             out_id_q;
  logic             last_grant;
  logic             grant0;
  logic             grant1;
  logic             accept;
  logic             last_bit;

  // The shift register presents the current bit at position 0, so the
  // running sum always adds shift_q[0].
  assign count_sum = count_q + CNT_W'(shift_q[0]);
  assign last_bit  = (index_q == LAST_IDX);

  assign bus.out_count  = out_count_q;
  assign bus.out_result = out_result_q;
  assign bus.out_id     = out_id_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    grant0         = 1'b0;
    grant1         = 1'b0;
    accept         = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.out_valid  = 1'b0;
    bus.busy       = 1'b0;
    unique case (state)
      IDLE: begin
        // Under contention the requester that did not win last time is served.
        grant0         = bus.req0_valid && (!bus.req1_valid || last_grant);
        grant1         = bus.req1_valid && (!bus.req0_valid || !last_grant);
        bus.req0_ready = grant0;
        bus.req1_ready = grant1;
        accept         = grant0 || grant1;
        if (accept) begin
          state_next = SCAN;
        end
      end
      SCAN: begin
        bus.busy = 1'b1;
        if (last_bit) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q      <= '0;
      count_q      <= '0;
      index_q      <= '0;
      last_grant   <= 1'b1;
      out_id_q     <= 1'b0;
      out_count_q  <= '0;
      out_result_q <= 1'b0;
    end else if (accept) begin
      shift_q    <= grant1 ? bus.req1_data : bus.req0_data;
      out_id_q   <= grant1;
      last_grant <= grant1;
      count_q    <= '0;
      index_q    <= '0;
    end else if (state == SCAN) begin
      shift_q <= shift_q >> 1;
      count_q <= count_sum;
      index_q <= index_q + IDX_W'(1);
      // Result registers change only on entry to HOLD, so they stay stable
      // through IDLE and SCAN of the next word.
      if (last_bit) begin
        out_count_q  <= count_sum;
        out_result_q <= (count_sum >= THR);
      end
    end
  end

endmodule
